// File: rtl/urng_pkg.sv
// Shared constants and types for the Tausworthe URNG checker/generator pair.
// Holds the three component shift/mask sets, the checker FSM state enum and the minimum seeds.
package urng_pkg;

    localparam logic [31:0] S0_MASK = 32'hFFFF_FFFE;
    localparam int          S0_SH_A = 13;
    localparam int          S0_SH_B = 19;
    localparam int          S0_SH_C = 12;

    localparam logic [31:0] S1_MASK = 32'hFFFF_FFF8;
    localparam int          S1_SH_A = 2;
    localparam int          S1_SH_B = 25;
    localparam int          S1_SH_C = 4;

    localparam logic [31:0] S2_MASK = 32'hFFFF_FFF0;
    localparam int          S2_SH_A = 3;
    localparam int          S2_SH_B = 11;
    localparam int          S2_SH_C = 17;

    // A component degenerates if its seed has no bits above the masked-off LSBs.
    localparam logic [31:0] MIN_SEED1 = 32'd2;
    localparam logic [31:0] MIN_SEED2 = 32'd8;
    localparam logic [31:0] MIN_SEED3 = 32'd16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } chkState_t;

    function automatic logic [31:0] tausComponent(
        input logic [31:0] s,
        input logic [31:0] mask,
        input int          shA,
        input int          shB,
        input int          shC
    );
        logic [31:0] mixed;
        logic [31:0] upper;
        mixed = (s << shA) ^ s;
        upper = (s & mask) << shC;
        return upper ^ (mixed >> shB);
    endfunction

endpackage

// File: rtl/taus_step.sv
// One combinational step of the three-component Tausworthe generator.
// Shared by the URNG producer and the stream checker so both sides advance identically.
module taus_step
    import urng_pkg::*;
(
    input  logic [31:0] state0,
    input  logic [31:0] state1,
    input  logic [31:0] state2,
    output logic [31:0] next0,
    output logic [31:0] next1,
    output logic [31:0] next2,
    output logic [31:0] word
);

    assign next0 = tausComponent(state0, S0_MASK, S0_SH_A, S0_SH_B, S0_SH_C);
    assign next1 = tausComponent(state1, S1_MASK, S1_SH_A, S1_SH_B, S1_SH_C);
    assign next2 = tausComponent(state2, S2_MASK, S2_SH_A, S2_SH_B, S2_SH_C);
    assign word  = next0 ^ next1 ^ next2;

endmodule

// File: rtl/urng_stream_checker.sv
// Checks a Tausworthe URNG word stream against a locally regenerated sequence.
// Optional build macro URNG_CHK_HIST_EN adds a 16-bin histogram of iData[31:28].
module urng_stream_checker
    import urng_pkg::*;
#(
    parameter int NUM_SAMPLES = 1024,
    parameter int CNT_W       = 24
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             iStart,
    input  logic [31:0]      iUrng_seed1,
    input  logic [31:0]      iUrng_seed2,
    input  logic [31:0]      iUrng_seed3,
    input  logic             iValid,
    input  logic [31:0]      iData,
    output logic             oReady,
    output logic [CNT_W-1:0] oSampleCnt,
    output logic [CNT_W-1:0] oErrCnt,
    output logic [CNT_W-1:0] oFirstErrIdx,
    output logic             oDone,
    output logic             oPass
`ifdef URNG_CHK_HIST_EN
    ,
    input  logic [3:0]       iHistSel,
    output logic [CNT_W-1:0] oHistCnt
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

    chkState_t        state;
    logic [31:0]      s0;
    logic [31:0]      s1;
    logic [31:0]      s2;
    logic [31:0]      n0;
    logic [31:0]      n1;
    logic [31:0]      n2;
    logic [31:0]      expWord;
    logic             accept;
    logic             vld_p1;
    logic             mismatch_p1;
    logic [CNT_W-1:0] idx_p1;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    taus_step uStep (
        .state0 (s0),
        .state1 (s1),
        .state2 (s2),
        .next0  (n0),
        .next1  (n1),
        .next2  (n2),
        .word   (expWord)
    );

    assign accept = iValid && oReady;
    assign oPass  = oDone && (oErrCnt == '0);

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state        <= IDLE;
            s0           <= '0;
            s1           <= '0;
            s2           <= '0;
            oReady       <= 1'b0;
            oSampleCnt   <= '0;
            oErrCnt      <= '0;
            oFirstErrIdx <= '0;
            oDone        <= 1'b0;
            vld_p1       <= 1'b0;
            mismatch_p1  <= 1'b0;
            idx_p1       <= '0;
        end else begin
            // stage p1: register the compare result with the index of the word it belongs to
            vld_p1      <= accept;
            mismatch_p1 <= accept && (iData != expWord);
            idx_p1      <= oSampleCnt;

            // retire stage p1 into the error statistics
            if (vld_p1 && mismatch_p1) begin
                oErrCnt <= satInc(oErrCnt);
                if (oErrCnt == '0) begin
                    oFirstErrIdx <= idx_p1;
                end
            end

            case (state)
                IDLE: begin
                    if (iStart) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    s0           <= iUrng_seed1;
                    s1           <= iUrng_seed2;
                    s2           <= iUrng_seed3;
                    oSampleCnt   <= '0;
                    oErrCnt      <= '0;
                    oFirstErrIdx <= '0;
                    oDone        <= 1'b0;
                    oReady       <= 1'b1;
                    state        <= RUN;
                end
                RUN: begin
                    if (accept) begin
                        s0         <= n0;
                        s1         <= n1;
                        s2         <= n2;
                        oSampleCnt <= oSampleCnt + 1'b1;
                        if (oSampleCnt == LAST_IDX) begin
                            oReady <= 1'b0;
                            state  <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    oDone <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    if (iStart) begin
                        state <= LOAD;
                    end
                end
                default: begin
                    oReady <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef URNG_CHK_HIST_EN
    logic [CNT_W-1:0] histBin [16];

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            for (int i = 0; i < 16; i++) begin
                histBin[i] <= '0;
            end
        end else if (state == LOAD) begin
            for (int i = 0; i < 16; i++) begin
                histBin[i] <= '0;
            end
        end else if (accept) begin
            histBin[iData[31:28]] <= satInc(histBin[iData[31:28]]);
        end
    end

    assign oHistCnt = histBin[iHistSel];
`endif

endmodule
